// File: rtl/mmio_vga_plotter.sv
// Bus-mapped pixel plotter: register file, command FIFO and a raster
// draw engine feeding vga_adapter through a valid/ready pixel port.
module mmio_vga_plotter #(
  parameter int COORD_W    = 16,
  parameter int COLOUR_W   = 9,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cs,
  input  logic                W,
  input  logic [2:0]          addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic [COORD_W-1:0]  plot_x,
  output logic [COORD_W-1:0]  plot_y,
  output logic [COLOUR_W-1:0] plot_colour,
  output logic                plot_valid,
  input  logic                plot_ready,
  output logic                done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [COORD_W-1:0] C1 = COORD_W'(1);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [COORD_W-1:0]  x;
    logic [COORD_W-1:0]  y;
    logic [COORD_W-1:0]  w;
    logic [COORD_W-1:0]  h;
    logic [COLOUR_W-1:0] c;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, LOAD, DRAW} state_t;

  logic [COORD_W-1:0]  x_r, y_r, w_r, h_r;
  logic [COLOUR_W-1:0] c_r;

  cmd_t          pend;
  logic          pend_v;
  cmd_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic          ovf;

  state_t             state;
  cmd_t               cur;
  logic [COORD_W-1:0] cx, cy, xe, ye;
  logic               valid;

  logic wr, rd, cmd_go, full, pop, push_ok, busy, last;
  cmd_t rect_snap, pix_snap;
  logic [31:0] rd_mux;

  assign wr      = cs & W;
  assign rd      = cs & ~W;
  assign cmd_go  = wr && addr == 3'd3 && (wdata[1] | wdata[0]);
  assign full    = cnt == DEPTH;
  assign pop     = state == IDLE && cnt != '0;
  // A full FIFO still takes the entry when the engine pops that cycle
  assign push_ok = pend_v && (!full || pop);
  assign busy    = cnt != '0 || state != IDLE || pend_v;
  assign last    = cx == xe && cy == ye;

  assign rect_snap = '{x: x_r, y: y_r,
                       w: (w_r == '0) ? C1 : w_r,
                       h: (h_r == '0) ? C1 : h_r,
                       c: c_r};
  assign pix_snap  = '{x: x_r, y: y_r, w: C1, h: C1, c: c_r};

  assign plot_x      = cx;
  assign plot_y      = cy;
  assign plot_colour = cur.c;
  assign plot_valid  = valid;
  assign done        = valid & plot_ready & last;

  always_comb begin
    rd_mux = '0;
    case (addr)
      3'd0: rd_mux = (32'(y_r) << 16) | 32'(x_r);
      3'd1: rd_mux = 32'(c_r);
      3'd2: rd_mux = (32'(h_r) << 16) | 32'(w_r);
      3'd4: rd_mux = {17'b0, 7'(cnt), 5'b0, ovf, full, busy};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= pend;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_r    <= '0;
      y_r    <= '0;
      w_r    <= '0;
      h_r    <= '0;
      c_r    <= '0;
      pend   <= '0;
      pend_v <= 1'b0;
      wp     <= '0;
      rp     <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      rdata  <= '0;
      state  <= IDLE;
      cur    <= '0;
      cx     <= '0;
      cy     <= '0;
      xe     <= '0;
      ye     <= '0;
      valid  <= 1'b0;
    end else begin
      if (wr) begin
        case (addr)
          3'd0: begin
            x_r <= wdata[COORD_W-1:0];
            y_r <= wdata[16+COORD_W-1:16];
          end
          3'd1: c_r <= wdata[COLOUR_W-1:0];
          3'd2: begin
            w_r <= wdata[COORD_W-1:0];
            h_r <= wdata[16+COORD_W-1:16];
          end
          default: ;
        endcase
      end

      // Snapshot is taken from pre-edge register values
      pend_v <= cmd_go;
      if (cmd_go) pend <= wdata[1] ? rect_snap : pix_snap;

      if (push_ok) wp <= wp + 1'b1;
      if (pop)     rp <= rp + 1'b1;
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase

      if (wr && addr == 3'd4 && wdata[2]) ovf <= 1'b0;
      if (pend_v && !push_ok)             ovf <= 1'b1;

      if (rd) rdata <= rd_mux;

      case (state)
        IDLE: begin
          if (pop) begin
            cur   <= mem[rp];
            state <= LOAD;
          end
        end
        LOAD: begin
          cx    <= cur.x;
          cy    <= cur.y;
          xe    <= cur.x + cur.w - C1;
          ye    <= cur.y + cur.h - C1;
          valid <= 1'b1;
          state <= DRAW;
        end
        DRAW: begin
          if (plot_ready) begin
            if (cx != xe) begin
              cx <= cx + C1;
            end else if (cy != ye) begin
              cx <= cur.x;
              cy <= cy + C1;
            end else begin
              valid <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_vga_plotter.sv
// Directed bench for mmio_vga_plotter with a pixel scoreboard
// checked by a negedge monitor.
module tb_mmio_vga_plotter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs, W;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [15:0] plot_x, plot_y;
  logic [8:0]  plot_colour;
  logic        plot_valid, plot_ready, done;

  mmio_vga_plotter dut (
    .clk(clk), .reset(reset), .cs(cs), .W(W),
    .addr(addr), .wdata(wdata), .rdata(rdata),
    .plot_x(plot_x), .plot_y(plot_y),
    .plot_colour(plot_colour), .plot_valid(plot_valid),
    .plot_ready(plot_ready), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int c;
    bit last;
  } px_t;

  px_t q[$];
  int tests = 0;
  int fails = 0;
  int acc = 0;
  int vcyc = 0;
  bit hold_v = 0;
  logic [15:0] hx, hy;
  logic [8:0]  hc;
  logic [31:0] rv;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cs = 1; W = 1; addr = a; wdata = d;
    @(posedge clk); #1;
    cs = 0; W = 0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    cs = 1; W = 0; addr = a;
    @(posedge clk); #1;
    cs = 0;
    d = rdata;
  endtask

  task automatic push_rect(input int x, input int y, input int w,
                           input int h, input int c);
    for (int r = 0; r < h; r++)
      for (int k = 0; k < w; k++)
        q.push_back('{(x + k) & 'hFFFF, (y + r) & 'hFFFF, c,
                      (r == h - 1 && k == w - 1)});
  endtask

  task automatic drain(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      if (q.size() == 0 && !plot_valid) break;
      @(posedge clk); #1;
    end
    chk(tag, q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (hold_v) begin
        chk("hold_v", plot_valid, 1);
        chk("hold_x", plot_x, hx);
        chk("hold_y", plot_y, hy);
        chk("hold_c", plot_colour, hc);
      end
      hold_v = 0;
      if (plot_valid) vcyc++;
      if (plot_valid && plot_ready) begin
        px_t e;
        acc++;
        tests++;
        assert (q.size() != 0) else begin
          fails++;
          $error("FAIL unexpected_pixel got %h,%h expected none",
                 plot_x, plot_y);
        end
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("px_x", plot_x, e.x);
          chk("px_y", plot_y, e.y);
          chk("px_c", plot_colour, e.c);
          chk("px_done", done, e.last);
        end
      end else if (plot_valid) begin
        hold_v = 1;
        hx = plot_x;
        hy = plot_y;
        hc = plot_colour;
        chk("done_stall", done, 0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; cs = 0; W = 0; addr = 0; wdata = 0; plot_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", plot_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_x", plot_x, 0);
    chk("rst_c", plot_colour, 0);
    chk("rst_rdata", rdata, 0);
    reset = 0;
    rd(3'd4, rv);
    chk("rst_status", rv, 0);

    // single pixel, latency E0+3
    wr(3'd0, 32'h0005_0003);
    wr(3'd1, 32'h0000_01FF);
    rd(3'd0, rv);
    chk("rd_xy", rv, 32'h0005_0003);
    plot_ready = 1;
    push_rect(3, 5, 1, 1, 'h1FF);
    wr(3'd3, 32'd1);
    chk("lat_e0", plot_valid, 0);
    @(posedge clk); #1;
    chk("lat_e1", plot_valid, 0);
    @(posedge clk); #1;
    chk("lat_e2", plot_valid, 0);
    @(posedge clk); #1;
    chk("lat_e3", plot_valid, 1);
    @(posedge clk); #1;
    chk("lat_e4", plot_valid, 0);
    drain("pix_drain", 20);

    // 3x2 rectangle
    wr(3'd2, 32'h0002_0003);
    wr(3'd0, 32'h000A_000A);
    push_rect(10, 10, 3, 2, 'h1FF);
    wr(3'd3, 32'd2);
    drain("rect_drain", 40);

    // same rectangle with ready toggling
    plot_ready = 0;
    vcyc = 0;
    push_rect(10, 10, 3, 2, 'h1FF);
    wr(3'd3, 32'd2);
    for (int k = 0; k < 30; k++) begin
      plot_ready = k[0];
      @(posedge clk); #1;
    end
    chk("tog_cycles", vcyc, 11);
    chk("tog_drain", q.size(), 0);

    // overflow: engine holds one, FIFO takes eight, tenth dropped
    plot_ready = 0;
    for (int i = 0; i < 10; i++) begin
      wr(3'd0, (i << 16) | i);
      if (i < 9) push_rect(i, i, 1, 1, 'h1FF);
      wr(3'd3, 32'd1);
    end
    repeat (2) @(posedge clk);
    #1;
    rd(3'd4, rv);
    chk("ovf_status", rv, 32'h0000_0807);
    wr(3'd4, 32'h4);
    rd(3'd4, rv);
    chk("ovf_clear", rv, 32'h0000_0803);
    acc = 0;
    plot_ready = 1;
    drain("ovf_drain", 200);
    chk("ovf_count", acc, 9);

    // wrap past the maximum coordinate
    wr(3'd0, 32'h0000_FFFF);
    wr(3'd2, 32'h0001_0002);
    push_rect('hFFFF, 0, 2, 1, 'h1FF);
    wr(3'd3, 32'd2);
    drain("wrap_drain", 40);

    // reset during the third pixel of a 4x4 with two queued
    wr(3'd0, 32'h0);
    wr(3'd2, 32'h0004_0004);
    acc = 0;
    push_rect(0, 0, 4, 4, 'h1FF);
    push_rect(0, 0, 1, 1, 'h1FF);
    push_rect(0, 0, 1, 1, 'h1FF);
    wr(3'd3, 32'd2);
    wr(3'd3, 32'd1);
    wr(3'd3, 32'd1);
    for (int i = 0; i < 100; i++) begin
      if (acc == 2 && plot_valid) break;
      @(posedge clk); #1;
    end
    chk("mid_reach", acc, 2);
    reset = 1;
    @(posedge clk); #1;
    q.delete();
    chk("mid_valid", plot_valid, 0);
    chk("mid_rdata", rdata, 0);
    chk("mid_done", done, 0);
    reset = 0;
    rd(3'd4, rv);
    chk("mid_status", rv, 0);
    repeat (30) @(posedge clk);
    #1;
    chk("mid_nopix", acc, 2);
    chk("mid_idle", plot_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
